// File: rtl/nco_pkg.sv
// Shared definitions for the PI-steered NCO: lock-detector states and default
// increment constants.
package nco_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    localparam logic [15:0] NCO_INC_INIT = 16'h1000;
    localparam logic [15:0] NCO_INC_MIN  = 16'h0400;
    localparam logic [15:0] NCO_INC_MAX  = 16'h2000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nco_lock_det.sv
// Lock detector: SEARCH/LOCKED FSM counting consecutive valid error samples.
// Compiled in only when NCO_PHASE_PI_LOCK_DET_EN is defined; otherwise locked is 0.
module nco_lock_det
    import nco_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned LOCK_THRESH  = 512,
    parameter int unsigned LOCK_COUNT   = 64,
    parameter int unsigned UNLOCK_COUNT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] err_tdata,
    input  logic                    err_tvalid,
    output logic                    locked
);

`ifdef NCO_PHASE_PI_LOCK_DET_EN
    localparam int CW = $clog2(max_int(LOCK_COUNT, UNLOCK_COUNT) + 1);

    lock_state_e      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] err_mag;
    logic             small_err;

    // The most negative input has no positive twin, so its magnitude saturates.
    always_comb begin
        if (err_tdata == {1'b1, {(WIDTH-1){1'b0}}})
            err_mag = {1'b0, {(WIDTH-1){1'b1}}};
        else if (err_tdata[WIDTH-1])
            err_mag = $unsigned(-err_tdata);
        else
            err_mag = $unsigned(err_tdata);
    end

    assign small_err = (err_mag < WIDTH'(LOCK_THRESH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = SEARCH;
            cnt_d   = '0;
        end else if (err_tvalid) begin
            unique case (state_q)
                SEARCH: begin
                    if (!small_err)
                        cnt_d = '0;
                    else if (cnt_q == CW'(LOCK_COUNT - 1)) begin
                        state_d = LOCKED;
                        cnt_d   = '0;
                    end else
                        cnt_d = cnt_q + 1'b1;
                end
                LOCKED: begin
                    if (small_err)
                        cnt_d = '0;
                    else if (cnt_q == CW'(UNLOCK_COUNT - 1)) begin
                        state_d = SEARCH;
                        cnt_d   = '0;
                    end else
                        cnt_d = cnt_q + 1'b1;
                end
                default: begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign locked = (state_q == LOCKED);
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clr, err_tdata, err_tvalid};
    assign locked        = 1'b0;
`endif

endmodule

// File: rtl/nco_phase_pi.sv
// Two-stage PI-steered phase accumulator: stage 1 integrates the error into a
// clamped increment, stage 2 accumulates phase. Lock FSM gated by NCO_PHASE_PI_LOCK_DET_EN.
module nco_phase_pi
    import nco_pkg::*;
#(
    parameter int unsigned      WIDTH          = 16,
    parameter logic [WIDTH-1:0] INCREMENT_INIT = NCO_INC_INIT,
    parameter int unsigned      KP_SHIFT       = 4,
    parameter int unsigned      KI_SHIFT       = 8,
    parameter logic [WIDTH-1:0] INC_MIN        = NCO_INC_MIN,
    parameter logic [WIDTH-1:0] INC_MAX        = NCO_INC_MAX,
    parameter int unsigned      LOCK_THRESH    = 512,
    parameter int unsigned      LOCK_COUNT     = 64,
    parameter int unsigned      UNLOCK_COUNT   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic signed [WIDTH-1:0] err_tdata,
    input  logic                    err_tvalid,
    output logic        [WIDTH-1:0] phase_tdata,
    output logic                    phase_tvalid,
    output logic        [WIDTH-1:0] freq_tdata,
    output logic                    locked
);

    localparam int EW = WIDTH + 2;

    logic [WIDTH-1:0] inc_q, inc_d;
    logic [WIDTH-1:0] p_term_q;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic             v1_q, vout_q;

    logic signed [WIDTH-1:0] ki_term, kp_term;
    logic signed [EW-1:0]    inc_wide, inc_lo, inc_hi;

    assign ki_term = err_tdata >>> KI_SHIFT;
    assign kp_term = err_tdata >>> KP_SHIFT;

    // Two guard bits keep the integrator sum from wrapping before the clamp.
    assign inc_wide = $signed({2'b00, inc_q}) + $signed({{2{ki_term[WIDTH-1]}}, ki_term});
    assign inc_lo   = $signed({2'b00, INC_MIN});
    assign inc_hi   = $signed({2'b00, INC_MAX});

    always_comb begin
        if (inc_wide < inc_lo)
            inc_d = INC_MIN;
        else if (inc_wide > inc_hi)
            inc_d = INC_MAX;
        else
            inc_d = inc_wide[WIDTH-1:0];
    end

    assign phase_d = phase_q + inc_q + p_term_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_q    <= INCREMENT_INIT;
            p_term_q <= '0;
            phase_q  <= '0;
            v1_q     <= 1'b0;
            vout_q   <= 1'b0;
        end else if (clr) begin
            inc_q    <= INCREMENT_INIT;
            p_term_q <= '0;
            phase_q  <= '0;
            v1_q     <= 1'b0;
            vout_q   <= 1'b0;
        end else begin
            v1_q   <= err_tvalid;
            vout_q <= v1_q;
            if (err_tvalid) begin
                inc_q    <= inc_d;
                p_term_q <= kp_term;
            end
            if (v1_q)
                phase_q <= phase_d;
        end
    end

    assign phase_tdata  = phase_q;
    assign phase_tvalid = vout_q;
    assign freq_tdata   = inc_q;

    nco_lock_det #(
        .WIDTH        (WIDTH),
        .LOCK_THRESH  (LOCK_THRESH),
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT)
    ) u_lock_det (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .err_tdata  (err_tdata),
        .err_tvalid (err_tvalid),
        .locked     (locked)
    );

endmodule

// File: doc/nco_phase_pi.md
NCO_PHASE_PI -- requirements
Module: nco_phase_pi

Interface
REQ-001 SHALL have parameter WIDTH, default 16, phase/increment/error width in bits.
REQ-002 SHALL have parameter INCREMENT_INIT, default 16'h1000, increment value loaded at reset and on clr.
REQ-003 SHALL have parameter KP_SHIFT, default 4, proportional gain as arithmetic right shift of the error.
REQ-004 SHALL have parameter KI_SHIFT, default 8, integral gain as arithmetic right shift of the error.
REQ-005 SHALL have parameters INC_MIN, default 16'h0400, and INC_MAX, default 16'h2000, unsigned increment clamp bounds.
REQ-006 SHALL have parameters LOCK_THRESH, default 512; LOCK_COUNT, default 64; UNLOCK_COUNT, default 16.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 clr  input  1  synchronous clear of loop state to reset values.
REQ-010 err_tdata  input  WIDTH  signed two's-complement Costas phase error.
REQ-011 err_tvalid  input  1  error sample qualifier; no ready, every valid sample is consumed.
REQ-012 phase_tdata  output  WIDTH  unsigned accumulated phase, modulo 2^WIDTH.
REQ-013 phase_tvalid  output  1  phase qualifier.
REQ-014 freq_tdata  output  WIDTH  current clamped phase increment.
REQ-015 locked  output  1  lock indicator.

Function
REQ-016 Stage 1 (on err_tvalid) SHALL compute inc <= clamp(inc + (err >>>KI_SHIFT), INC_MIN, INC_MAX), evaluated in WIDTH+2 signed bits, never wrapping.
REQ-017 Stage 1 SHALL register p_term = err >>> KI_SHIFT-independent value err >>> KP_SHIFT and a stage-1 valid.
REQ-018 Stage 2 (on stage-1 valid) SHALL compute phase <= phase + inc + sign-extended p_term, modulo 2^WIDTH (wrap permitted).
REQ-019 phase_tvalid SHALL be asserted exactly 2 cycles after each err_tvalid cycle, for one cycle per sample; back-to-back samples give back-to-back outputs.
REQ-020 Without valid samples, phase_tdata, freq_tdata and inc SHALL hold.
REQ-021 freq_tdata SHALL equal the registered inc.
REQ-022 clr SHALL restore inc to INCREMENT_INIT, phase to 0, drain both valid stages, and return the lock FSM to SEARCH; clr overrides a simultaneous err_tvalid.
REQ-023 Lock FSM states: SEARCH, LOCKED; counter counts consecutive valid samples only.
REQ-024 SEARCH: |err| < LOCK_THRESH increments counter, else counter cleared; counter reaching LOCK_COUNT SHALL go LOCKED, counter cleared.
REQ-025 LOCKED: |err| >= LOCK_THRESH increments counter, else counter cleared; reaching UNLOCK_COUNT SHALL go SEARCH, counter cleared.
REQ-026 |err| of the most negative value SHALL saturate to 2^(WIDTH-1)-1; locked SHALL be high exactly in state LOCKED.

Reset
REQ-027 rst SHALL immediately, without a clock, force inc=INCREMENT_INIT, phase_tdata=0, phase_tvalid=0, stage-1 valid=0, p_term=0, state=SEARCH, counter=0, locked=0.
REQ-028 Reset mid-stream SHALL discard in-flight samples; no phase_tvalid follows for samples accepted before rst.

Configuration
REQ-029 Macro NCO_PHASE_PI_LOCK_DET_EN defined: lock FSM and counter per REQ-023..026 compiled in.
REQ-030 Macro undefined: no FSM or counter logic; locked tied to 0; all other behaviour identical.

Structure
REQ-031 Shared package nco_pkg SHALL hold lock-state enum (SEARCH, LOCKED) and default INCREMENT_INIT/INC_MIN/INC_MAX constants.
REQ-032 Lock detector SHALL be sub-module nco_lock_det (inputs clk, rst, clr, err_tdata, err_tvalid; output locked).

Verification
REQ-033 Reset, err=0 valid every cycle: phase_tdata 0x1000, 0x2000, ...; 16th output 0x0000 (wrap); latency 2 cycles.
REQ-034 err=+256 constant: freq_tdata 0x1001, 0x1002, ...; each phase step = inc + 16.
REQ-035 err=+32767 constant: freq_tdata rises to 0x2000 and stays; err=-32768 constant: settles at 0x0400, no wrap.
REQ-036 |err|=100 for 64 samples: locked rises after 64th; then 15 samples err=1000 keep lock, 16th drops it; gaps in err_tvalid do not break counts.
REQ-037 rst asserted asynchronously mid-stream: outputs reach reset values before next clk edge; no stale phase_tvalid afterwards.
REQ-038 clr with err_tvalid in same cycle: freq_tdata=0x1000, phase_tdata=0, no phase_tvalid for that sample, locked=0.
